// File: rtl/div_sequencer_pkg.sv
// Shared types for the EX-stage iterative divider: FSM state codes and
// the iteration-counter width helper.
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    localparam int DIV_WIDTH_DEFAULT = 32;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_sequencer_step.sv
// One combinational radix-2 restoring iteration: shift the next dividend
// bit into the partial remainder and try to subtract the divisor.
module div_step
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

    // The shifted remainder needs WIDTH+1 bits; when the divisor fits, the
    // difference is below the divisor, so its low WIDTH bits are exact.
    always_comb begin
        shifted  = {rem, q[WIDTH-1]};
        fits     = (shifted >= {1'b0, dvs});
        trial    = shifted[WIDTH-1:0] - dvs;
        rem_next = fits ? trial : shifted[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU unit: quotient to LO, remainder to HI, with flush cancel.
// Optional DIV_ZERO_FAST_EN: a zero divisor bypasses the iterations.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic             div_cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_busy,
    output logic             div_complete,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             busy_q, busy_d;
    logic             complete_q, complete_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem, step_q;
    logic             a_neg, b_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .q        (quo_q),
        .dvs      (dvs_q),
        .rem_next (step_rem),
        .q_next   (step_q)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dbz_d      = dbz_q;
        a_neg      = div_signed & dividend[WIDTH-1];
        b_neg      = div_signed & divisor[WIDTH-1];

        unique case (state_q)
            DIV_IDLE: begin
                if (div_start && !div_cancel) begin
                    dbz_d   = (divisor == '0);
                    rem_d   = '0;
                    quo_d   = a_neg ? -dividend : dividend;
                    dvs_d   = b_neg ? -divisor : divisor;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    cnt_d   = '0;
                    state_d = DIV_CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (divisor == '0) begin
                        lo_d    = '1;
                        hi_d    = dividend;
                        state_d = DIV_DONE;
                    end
`endif
                end
            end
            DIV_CALC: begin
                if (div_cancel) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_q;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DIV_FIX;
                    end
                end
            end
            DIV_FIX: begin
                if (div_cancel) begin
                    state_d = DIV_IDLE;
                end else begin
                    lo_d    = q_neg_q ? -quo_q : quo_q;
                    hi_d    = r_neg_q ? -rem_q : rem_q;
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        // Status outputs are registered copies of the state being entered.
        busy_d     = (state_d == DIV_CALC) || (state_d == DIV_FIX);
        complete_d = (state_d == DIV_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= DIV_IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dbz_q      <= dbz_d;
        end
    end

    assign div_busy     = busy_q;
    assign div_complete = complete_q;
    assign div_hi       = hi_q;
    assign div_lo       = lo_q;
    assign div_by_zero  = dbz_q;

endmodule
